// File: rtl/eb_rr_arbiter.sv
// eb_rr_arbiter: N-to-1 round-robin arbiter feeding a single registered
// elastic-buffer slot. Multi-beat packets lock the grant to their requester
// from the first beat until the beat carrying last has transferred.
// FULL_THROUGHPUT selects between a pipelined slot (reload while popping)
// and a half-bandwidth slot (accept only when empty).

module eb_rr_arbiter #(
  parameter int N_REQ           = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int FULL_THROUGHPUT = 1,
  parameter int ID_WIDTH        = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            valid_in,
  input  logic [N_REQ-1:0]            last_in,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]            ready_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic [ID_WIDTH-1:0]         id_out,
  output logic                        last_out
);

  localparam logic [ID_WIDTH:0]   N_REQ_W = (ID_WIDTH+1)'(N_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(N_REQ - 1);

  // Slot state
  logic                  full_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [ID_WIDTH-1:0]   id_r;
  logic                  last_r;

  // Arbitration state
  logic [ID_WIDTH-1:0]   ptr_r;
  logic                  lock_r;
  logic [ID_WIDTH-1:0]   owner_r;

  // Combinational decision signals
  logic                  write_en_s;
  logic                  req_ok_s;
  logic                  xfer_s;
  logic [ID_WIDTH-1:0]   sel_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  sel_last_s;

  // Slot write enable: pipelined slot may reload in the cycle it is popped
  always_comb begin
    if (FULL_THROUGHPUT != 0) begin
      write_en_s = ready_in | ~full_r;
    end else begin
      write_en_s = ~full_r;
    end
  end

  // Requester selection: locked owner, else first valid scanning from ptr_r
  always_comb begin
    logic [ID_WIDTH:0]   scan_v;
    logic [ID_WIDTH-1:0] cand_v;
    scan_v   = '0;
    cand_v   = '0;
    sel_s    = owner_r;
    req_ok_s = 1'b0;
    if (lock_r) begin
      // Owner keeps the grant even while idle; the bubble is intentional.
      sel_s    = owner_r;
      req_ok_s = valid_in[owner_r];
    end else begin
      sel_s    = ptr_r;
      req_ok_s = |valid_in;
      // Walk from the farthest candidate to the nearest so the nearest wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        scan_v = {1'b0, ptr_r} + (ID_WIDTH+1)'(k);
        scan_v = (scan_v >= N_REQ_W) ? (scan_v - N_REQ_W) : scan_v;
        cand_v = scan_v[ID_WIDTH-1:0];
        sel_s  = valid_in[cand_v] ? cand_v : sel_s;
      end
    end
  end

  // Payload and last-flag mux for the selected requester
  always_comb begin
    sel_data_s = '0;
    sel_last_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_s == ID_WIDTH'(i)) begin
        sel_data_s = data_in[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last_s = last_in[i];
      end else begin
        sel_data_s = sel_data_s;
        sel_last_s = sel_last_s;
      end
    end
  end

  // One-hot accept towards the selected requester only
  always_comb begin
    ready_out = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ready_out[i] = write_en_s & req_ok_s & (sel_s == ID_WIDTH'(i));
    end
  end

  assign xfer_s = write_en_s & req_ok_s;

  // Output slot: load on transfer, empty on an unanswered write, and in the
  // half-bandwidth build drain on a downstream pop (write_en is low there)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r <= 1'b0;
      data_r <= '0;
      id_r   <= '0;
      last_r <= 1'b0;
    end else if (write_en_s) begin
      if (req_ok_s) begin
        full_r <= 1'b1;
        data_r <= sel_data_s;
        id_r   <= sel_s;
        last_r <= sel_last_s;
      end else begin
        full_r <= 1'b0;
      end
    end else if (full_r && ready_in) begin
      full_r <= 1'b0;
    end
  end

  // Grant lock and round-robin pointer advance on each transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r   <= '0;
      lock_r  <= 1'b0;
      owner_r <= '0;
    end else if (xfer_s) begin
      if (sel_last_s) begin
        lock_r <= 1'b0;
        ptr_r  <= (sel_s == LAST_ID) ? '0 : (sel_s + ID_WIDTH'(1));
      end else begin
        lock_r  <= 1'b1;
        owner_r <= sel_s;
      end
    end
  end

  assign valid_out = full_r;
  assign data_out  = data_r;
  assign id_out    = id_r;
  assign last_out  = last_r;

endmodule

// File: tb/tb_eb_rr_arbiter.sv
// Directed bench for eb_rr_arbiter: one pipelined instance (dut) and one
// half-bandwidth instance (dut_hb), each checked against hand-computed values.

module tb_eb_rr_arbiter;

  logic        clk;
  logic        rst;

  logic [3:0]  valid_in, last_in, ready_out;
  logic [63:0] data_in;
  logic        valid_out, ready_in, last_out;
  logic [15:0] data_out;
  logic [1:0]  id_out;

  logic [3:0]  hb_valid_in, hb_last_in, hb_ready_out;
  logic [63:0] hb_data_in;
  logic        hb_valid_out, hb_ready_in, hb_last_out;
  logic [15:0] hb_data_out;
  logic [1:0]  hb_id_out;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  eb_rr_arbiter #(.N_REQ(4), .DATA_WIDTH(16), .FULL_THROUGHPUT(1)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .last_in(last_in), .data_in(data_in),
    .ready_out(ready_out), .valid_out(valid_out), .ready_in(ready_in),
    .data_out(data_out), .id_out(id_out), .last_out(last_out)
  );

  eb_rr_arbiter #(.N_REQ(4), .DATA_WIDTH(16), .FULL_THROUGHPUT(0)) dut_hb (
    .clk(clk), .rst(rst),
    .valid_in(hb_valid_in), .last_in(hb_last_in), .data_in(hb_data_in),
    .ready_out(hb_ready_out), .valid_out(hb_valid_out), .ready_in(hb_ready_in),
    .data_out(hb_data_out), .id_out(hb_id_out), .last_out(hb_last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester obligation: payload held stable while valid waits for ready
  logic [3:0]  pv, pr;
  logic [63:0] pd;
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (pv[i] && !pr[i] && valid_in[i])
          assert (data_in[i*16 +: 16] == pd[i*16 +: 16])
            else $error("payload changed while waiting on lane %0d", i);
      end
    end
    pv <= valid_in;
    pr <= ready_out;
    pd <= data_in;
  end

  task automatic set_data(input logic [15:0] base);
    data_in[15:0]  = base;
    data_in[31:16] = base + 16'd1;
    data_in[47:32] = base + 16'd2;
    data_in[63:48] = base + 16'd3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 4'b0000; last_in = 4'b0000; ready_in = 1'b0; set_data(16'h0000);
    hb_valid_in = 4'b0000; hb_last_in = 4'b0000; hb_ready_in = 1'b0; hb_data_in = 64'd0;
    #2;
    chk_cnt++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_out); else pass_cnt++;
    chk_cnt++; if (data_out !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", data_out); else pass_cnt++;
    chk_cnt++; if (id_out !== 2'd0) $display("FAIL reset_id: got %0d expected 0", id_out); else pass_cnt++;
    chk_cnt++; if (last_out !== 1'b0) $display("FAIL reset_last: got %b expected 0", last_out); else pass_cnt++;
    chk_cnt++; if (ready_out !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", ready_out); else pass_cnt++;
    chk_cnt++; if (hb_valid_out !== 1'b0) $display("FAIL reset_hb_valid: got %b expected 0", hb_valid_out); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_rdy;
    @(negedge clk);
    valid_in = 4'b1111; last_in = 4'b1111; ready_in = 1'b1; set_data(16'h1000);
    #1;
    chk_cnt++; if (ready_out !== 4'b0001) $display("FAIL rr_first_ready: got %b expected 0001", ready_out); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      exp_rdy = 4'b0001 << ((k + 1) % 4);
      chk_cnt++;
      if ({valid_out, id_out, data_out, ready_out} !== {1'b1, exp_id[k], 16'h1000 + 16'(exp_id[k]), exp_rdy})
        $display("FAIL rr_cycle%0d: got v=%b id=%0d d=%h rdy=%b expected v=1 id=%0d d=%h rdy=%b",
                 k, valid_out, id_out, data_out, ready_out, exp_id[k], 16'h1000 + 16'(exp_id[k]), exp_rdy);
      else pass_cnt++;
    end
    valid_in = 4'b0000;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    valid_in = 4'b0100;
    #1;
    chk_cnt++; if (valid_out !== 1'b0) $display("FAIL wrap_drained: got %b expected 0", valid_out); else pass_cnt++;
    @(negedge clk);
    valid_in = 4'b1001;
    #1;
    chk_cnt++; if (dut.ptr_r !== 2'd3) $display("FAIL wrap_ptr3: got %0d expected 3", dut.ptr_r); else pass_cnt++;
    chk_cnt++; if (ready_out !== 4'b1000) $display("FAIL wrap_ready3: got %b expected 1000", ready_out); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (id_out !== 2'd3) $display("FAIL wrap_id3: got %0d expected 3", id_out); else pass_cnt++;
    chk_cnt++; if (ready_out !== 4'b0001) $display("FAIL wrap_ready0: got %b expected 0001", ready_out); else pass_cnt++;
    @(negedge clk);
    valid_in = 4'b0000;
    #1;
    chk_cnt++; if ({id_out, data_out} !== {2'd0, 16'h1000}) $display("FAIL wrap_id0: got id=%0d d=%h expected id=0 d=1000", id_out, data_out); else pass_cnt++;
    chk_cnt++; if (dut.ptr_r !== 2'd1) $display("FAIL wrap_ptr1: got %0d expected 1", dut.ptr_r); else pass_cnt++;
  endtask

  task automatic test_lock();
    @(negedge clk);
    data_in[31:16] = 16'hB1A0; data_in[47:32] = 16'h0C20;
    valid_in = 4'b0110; last_in = 4'b0100;
    #1;
    chk_cnt++; if (ready_out !== 4'b0010) $display("FAIL lock_start_ready: got %b expected 0010", ready_out); else pass_cnt++;
    @(negedge clk);
    data_in[31:16] = 16'hB1B0;
    #1;
    chk_cnt++; if ({id_out, data_out, last_out, ready_out} !== {2'd1, 16'hB1A0, 1'b0, 4'b0010})
      $display("FAIL lock_beat_a: got id=%0d d=%h l=%b rdy=%b expected id=1 d=b1a0 l=0 rdy=0010", id_out, data_out, last_out, ready_out); else pass_cnt++;
    @(negedge clk);
    data_in[31:16] = 16'hB1C0; last_in = 4'b0110;
    #1;
    chk_cnt++; if ({id_out, data_out, last_out, ready_out} !== {2'd1, 16'hB1B0, 1'b0, 4'b0010})
      $display("FAIL lock_beat_b: got id=%0d d=%h l=%b rdy=%b expected id=1 d=b1b0 l=0 rdy=0010", id_out, data_out, last_out, ready_out); else pass_cnt++;
    @(negedge clk);
    data_in[31:16] = 16'hB1D0; last_in = 4'b0100;
    #1;
    chk_cnt++; if ({id_out, data_out, last_out, ready_out} !== {2'd1, 16'hB1C0, 1'b1, 4'b0100})
      $display("FAIL lock_beat_c: got id=%0d d=%h l=%b rdy=%b expected id=1 d=b1c0 l=1 rdy=0100", id_out, data_out, last_out, ready_out); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if ({id_out, data_out, last_out, ready_out} !== {2'd2, 16'h0C20, 1'b1, 4'b0010})
      $display("FAIL lock_req2: got id=%0d d=%h l=%b rdy=%b expected id=2 d=0c20 l=1 rdy=0010", id_out, data_out, last_out, ready_out); else pass_cnt++;
    @(negedge clk);
    data_in[31:16] = 16'hB1E0; valid_in = 4'b0100; last_in = 4'b0100;
    #1;
    chk_cnt++; if ({id_out, data_out, last_out, ready_out} !== {2'd1, 16'hB1D0, 1'b0, 4'b0000})
      $display("FAIL lock_gap_start: got id=%0d d=%h l=%b rdy=%b expected id=1 d=b1d0 l=0 rdy=0000", id_out, data_out, last_out, ready_out); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if ({valid_out, ready_out} !== {1'b0, 4'b0000})
      $display("FAIL lock_bubble1: got v=%b rdy=%b expected v=0 rdy=0000", valid_out, ready_out); else pass_cnt++;
    @(negedge clk);
    valid_in = 4'b0110; last_in = 4'b0110;
    #1;
    chk_cnt++; if ({valid_out, ready_out} !== {1'b0, 4'b0010})
      $display("FAIL lock_bubble2: got v=%b rdy=%b expected v=0 rdy=0010", valid_out, ready_out); else pass_cnt++;
    @(negedge clk);
    valid_in = 4'b0100;
    #1;
    chk_cnt++; if ({id_out, data_out, last_out, ready_out} !== {2'd1, 16'hB1E0, 1'b1, 4'b0100})
      $display("FAIL lock_resume: got id=%0d d=%h l=%b rdy=%b expected id=1 d=b1e0 l=1 rdy=0100", id_out, data_out, last_out, ready_out); else pass_cnt++;
    @(negedge clk);
    valid_in = 4'b0000;
    #1;
    chk_cnt++; if (id_out !== 2'd2) $display("FAIL lock_after: got %0d expected 2", id_out); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_data(16'h2000); valid_in = 4'b1111; last_in = 4'b1111; ready_in = 1'b1;
    #1;
    chk_cnt++; if (ready_out !== 4'b1000) $display("FAIL bp_first_ready: got %b expected 1000", ready_out); else pass_cnt++;
    @(negedge clk);
    ready_in = 1'b0;
    #1;
    chk_cnt++; if ({id_out, data_out, ready_out} !== {2'd3, 16'h2003, 4'b0000})
      $display("FAIL bp_loaded: got id=%0d d=%h rdy=%b expected id=3 d=2003 rdy=0000", id_out, data_out, ready_out); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk_cnt++;
      if ({valid_out, id_out, data_out, ready_out} !== {1'b1, 2'd3, 16'h2003, 4'b0000})
        $display("FAIL bp_stall%0d: got v=%b id=%0d d=%h rdy=%b expected v=1 id=3 d=2003 rdy=0000",
                 k, valid_out, id_out, data_out, ready_out);
      else pass_cnt++;
    end
    chk_cnt++; if (dut.ptr_r !== 2'd0) $display("FAIL bp_ptr_hold: got %0d expected 0", dut.ptr_r); else pass_cnt++;
    ready_in = 1'b1;
    #1;
    chk_cnt++; if (ready_out !== 4'b0001) $display("FAIL bp_release_ready: got %b expected 0001", ready_out); else pass_cnt++;
    @(negedge clk);
    valid_in = 4'b0000;
    #1;
    chk_cnt++; if ({valid_out, id_out, data_out} !== {1'b1, 2'd0, 16'h2000})
      $display("FAIL bp_reload: got v=%b id=%0d d=%h expected v=1 id=0 d=2000", valid_out, id_out, data_out); else pass_cnt++;
  endtask

  task automatic test_half_bandwidth();
    logic       exp_v;
    logic [1:0] exp_id;
    logic [3:0] exp_rdy;
    @(negedge clk);
    hb_data_in = 64'h3003_3002_3001_3000;
    hb_valid_in = 4'b1111; hb_last_in = 4'b1111; hb_ready_in = 1'b1;
    #1;
    chk_cnt++; if (hb_ready_out !== 4'b0001) $display("FAIL hb_first_ready: got %b expected 0001", hb_ready_out); else pass_cnt++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      exp_v   = (k % 2) == 1;
      exp_id  = 2'((k - 1) / 2);
      exp_rdy = exp_v ? 4'b0000 : (4'b0001 << (k / 2));
      chk_cnt++;
      if (exp_v && ({hb_valid_out, hb_id_out, hb_ready_out} !== {1'b1, exp_id, exp_rdy}))
        $display("FAIL hb_cycle%0d: got v=%b id=%0d rdy=%b expected v=1 id=%0d rdy=%b",
                 k, hb_valid_out, hb_id_out, hb_ready_out, exp_id, exp_rdy);
      else if (!exp_v && ({hb_valid_out, hb_ready_out} !== {1'b0, exp_rdy}))
        $display("FAIL hb_cycle%0d: got v=%b rdy=%b expected v=0 rdy=%b",
                 k, hb_valid_out, hb_ready_out, exp_rdy);
      else pass_cnt++;
    end
    hb_valid_in = 4'b0000;
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    valid_in = 4'b0100; last_in = 4'b0000; ready_in = 1'b1;
    #1;
    chk_cnt++; if (ready_out !== 4'b0100) $display("FAIL mrst_ready: got %b expected 0100", ready_out); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if ({valid_out, id_out, dut.lock_r} !== {1'b1, 2'd2, 1'b1})
      $display("FAIL mrst_locked: got v=%b id=%0d lock=%b expected v=1 id=2 lock=1", valid_out, id_out, dut.lock_r); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if ({valid_out, id_out, data_out, last_out, dut.lock_r} !== {1'b0, 2'd0, 16'h0000, 1'b0, 1'b0})
      $display("FAIL mrst_async: got v=%b id=%0d d=%h l=%b lock=%b expected all 0",
               valid_out, id_out, data_out, last_out, dut.lock_r); else pass_cnt++;
    valid_in = 4'b1111; last_in = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_cnt++; if (ready_out !== 4'b0001) $display("FAIL mrst_restart_ready: got %b expected 0001", ready_out); else pass_cnt++;
    @(negedge clk);
    valid_in = 4'b0000;
    #1;
    chk_cnt++; if ({valid_out, id_out, data_out} !== {1'b1, 2'd0, 16'h2000})
      $display("FAIL mrst_restart: got v=%b id=%0d d=%h expected v=1 id=0 d=2000", valid_out, id_out, data_out); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_lock();
    test_backpressure();
    test_half_bandwidth();
    test_reset_mid_packet();
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
